reg_file_mp: RTL

Parametrised successor to the processor's integer register file: one write port, NUM_READ combinational read ports, same-cycle write-to-read bypass and an optional hardwired zero register. A sequenced clear engine zeroes the array one entry per cycle on request, without a full reset. Sits in the decode stage and is written from writeback.

---
 rtl/reg_file_mp_pkg.sv | 17 +
 rtl/reg_file_mp_if.sv | 31 +++
 rtl/reg_file_clear_fsm.sv | 74 +++++++
 rtl/reg_file_mp.sv | 84 ++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_mp_pkg;

    localparam int WORD_LEN_DEF          = 32;
    localparam int REG_FILE_SIZE_DEF     = 32;
    localparam int REG_FILE_ADDR_LEN_DEF = $clog2(REG_FILE_SIZE_DEF);
    localparam int NUM_READ_DEF          = 2;

    // Clear engine state encoding width; the encodings live in the FSM.
    typedef logic [1:0] clr_state_t;

    // Address width for a given depth; a single-entry file still gets one bit.
    function automatic int addr_len(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Write/read/clear bundle between decode/writeback and the register file.
interface reg_file_mp_if #(
    parameter int WORD_LEN      = reg_file_mp_pkg::WORD_LEN_DEF,
    parameter int REG_FILE_SIZE = reg_file_mp_pkg::REG_FILE_SIZE_DEF,
    parameter int NUM_READ      = reg_file_mp_pkg::NUM_READ_DEF
);
    import reg_file_mp_pkg::*;

    localparam int ADDR_LEN = addr_len(REG_FILE_SIZE);

    logic                         wr_en;
    logic [ADDR_LEN-1:0]          wr_addr;
    logic [WORD_LEN-1:0]          wr_data;
    logic                         wr_ready;
    logic [NUM_READ*ADDR_LEN-1:0] rd_addr;
    logic [NUM_READ*WORD_LEN-1:0] rd_data;
    logic                         clr_req;
    logic                         clr_busy;
    logic                         clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, clr_req,
        input  wr_ready, rd_data, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
        output wr_ready, rd_data, clr_busy, clr_done
    );

endinterface

// File: rtl/reg_file_clear_fsm.sv
// Sequenced clear engine: walks the array one entry per cycle and blocks
// external writes while it runs.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no clear in progress, writes accepted
//  CLEAR | zeroing entry[ptr] this cycle, writes blocked
//  DONE  | one-cycle completion pulse, writes accepted, new req taken
module reg_file_clear_fsm #(
    parameter int REG_FILE_SIZE = reg_file_mp_pkg::REG_FILE_SIZE_DEF
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               clr_req,
    output logic                                               clr_busy,
    output logic                                               clr_done,
    output logic                                               wr_ready,
    output logic                                               clr_we,
    output logic [reg_file_mp_pkg::addr_len(REG_FILE_SIZE)-1:0] clr_addr
);
    import reg_file_mp_pkg::*;

    localparam int ADDR_LEN = addr_len(REG_FILE_SIZE);

    localparam clr_state_t IDLE  = 2'd0;
    localparam clr_state_t CLEAR = 2'd1;
    localparam clr_state_t DONE  = 2'd2;

    localparam logic [ADDR_LEN-1:0] LAST = ADDR_LEN'(REG_FILE_SIZE - 1);

    clr_state_t          state;
    logic [ADDR_LEN-1:0] ptr;

    // State and pointer; a request arriving mid-clear is dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ptr <= '0;
                    if (clr_req) state <= CLEAR;
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= DONE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ADDR_LEN'(1);
                    end
                end
                DONE: begin
                    ptr   <= '0;
                    state <= clr_req ? CLEAR : IDLE;
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        clr_busy = (state == CLEAR);
        clr_done = (state == DONE);
        wr_ready = !clr_busy;
        clr_we   = clr_busy;
        clr_addr = ptr;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Integer register file: one write port, NUM_READ combinational read ports,
// optional write-to-read bypass and hardwired zero entry, sequenced clear.
module reg_file_mp #(
    parameter int WORD_LEN      = reg_file_mp_pkg::WORD_LEN_DEF,
    parameter int REG_FILE_SIZE = reg_file_mp_pkg::REG_FILE_SIZE_DEF,
    parameter int NUM_READ      = reg_file_mp_pkg::NUM_READ_DEF,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);
    import reg_file_mp_pkg::*;

    // Derived from the depth so it can never disagree with it.
    localparam int ADDR_LEN = addr_len(REG_FILE_SIZE);

    logic [WORD_LEN-1:0] mem [REG_FILE_SIZE];

    logic                clr_busy;
    logic                clr_done;
    logic                wr_ready;
    logic                clr_we;
    logic [ADDR_LEN-1:0] clr_addr;
    logic                wr_commit;

    // Addresses that never touch storage: the zero entry and anything past the end.
    function automatic logic addr_masked(input logic [ADDR_LEN-1:0] a);
        return ((ZERO_REG != 0) && (a == '0)) || (int'(a) >= REG_FILE_SIZE);
    endfunction

    reg_file_clear_fsm #(
        .REG_FILE_SIZE (REG_FILE_SIZE)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_ready (wr_ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;
    assign bus.wr_ready = wr_ready;

    // A write commits only when accepted and aimed at real, writable storage.
    assign wr_commit = bus.wr_en && wr_ready && !addr_masked(bus.wr_addr);

    // Array update; the clear wins, though external writes are blocked then anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] data;

        assign addr = bus.rd_addr[k*ADDR_LEN +: ADDR_LEN];

        // Read mux: masked addresses first, then same-cycle forwarding, then storage.
        always_comb begin
            if (addr_masked(addr)) begin
                data = '0;
            end else if ((BYPASS != 0) && wr_commit && (bus.wr_addr == addr)) begin
                data = bus.wr_data;
            end else begin
                data = mem[addr];
            end
        end

        assign bus.rd_data[k*WORD_LEN +: WORD_LEN] = data;
    end

endmodule
